// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access block: data widths, RISC-V load/store
// opcodes and funct3 codes, the FSM state encoding, and small helpers that
// derive bus byte enables and store lane data from the access size.
package mem_access_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int BE_W       = XLEN / 8;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 codes; stores share the encodings of the signed loads.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // size = funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store datum across every lane so the byte enables alone
  // pick the destination bytes.
  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/half of a bus word
// and sign- or zero-extends it according to funct3.
//   word   : raw 32-bit word returned by the data bus
//   lane   : byte offset of the access (addr[1:0])
//   funct3 : load type (LB/LH/LW/LBU/LHU)
//   data   : formatted value for the register file
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage. Non-memory instructions flow straight through to
// mem_wb. An aligned load/store stalls the stage (hold_o) while a single
// request/grant(/rvalid) handshake runs on the data bus; the formatted load
// result is presented in DONE. Misaligned accesses are flagged and
// suppressed; a bus that never answers is aborted after TIMEOUT_CYC cycles.
//   clk_100MHz, arst             : clock, async active-high reset
//   hold_ena_i                   : system hold (mem_wb not capturing)
//   instc_i, reg_*_i, mem_*_i    : instruction fields from ex_mem
//   bus_*_o / bus_*_i            : data-bus request side / response side
//   instc_o .. mem_wena_o        : fields to mem_wb
//   hold_o                       : stall request to the hazard controller
//   misalign_o, bus_err_o        : one-cycle error flags
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_100MHz,
  input  logic        arst,
  input  logic        hold_ena_i,
  input  logic [31:0] instc_i,
  input  logic        reg_wena_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        mem_rena_i,
  input  logic        mem_wena_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] instc_o,
  output logic        reg_wena_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        mem_rena_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_wena_o,
  output logic        hold_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  load_buf;
  logic [XLEN-1:0]  load_data;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic             err_q;

  logic             mem_op, misaligned, timeout, issue, capture;
  logic [2:0]       funct3;

  assign funct3     = instc_i[14:12];
  assign mem_op     = mem_rena_i | mem_wena_i;
  assign misaligned = mem_op & is_misaligned(funct3[1:0], mem_addr_i[1:0]);
  assign timeout    = ((state == ST_REQ) || (state == ST_RESP)) &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    hold_o     = 1'b0;
    bus_req_o  = 1'b0;
    bus_err_o  = 1'b0;
    misalign_o = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && !hold_ena_i && !arst) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            hold_o    = 1'b1;
            issue     = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        hold_o = 1'b1;
        if (timeout) begin
          // Request is withdrawn in the abort cycle so a late grant is moot.
          bus_err_o = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          bus_req_o = 1'b1;
          if (bus_gnt_i) state_nxt = bus_we_o ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        hold_o = 1'b1;
        if (timeout) begin
          bus_err_o = 1'b1;
          state_nxt = ST_DONE;
        end else if (bus_rvalid_i) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!hold_ena_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= ZERO_WORD;
      bus_be_o    <= '0;
      bus_wdata_o <= ZERO_WORD;
      load_buf    <= ZERO_WORD;
      f3_q        <= '0;
      lane_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nxt;

      // Counts cycles spent in the current wait state; restarts on any move.
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == ST_REQ) || (state == ST_RESP))
        wait_cnt <= wait_cnt + 1'b1;

      if (issue) begin
        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus_be_o    <= byte_en(funct3[1:0], mem_addr_i[1:0]);
        bus_wdata_o <= store_lanes(funct3[1:0], mem_wdata_i);
        bus_we_o    <= mem_wena_i;
        f3_q        <= funct3;
        lane_q      <= mem_addr_i[1:0];
      end

      if (capture) load_buf <= bus_rdata_i;

      if (bus_err_o)
        err_q <= 1'b1;
      else if ((state == ST_DONE) && (state_nxt == ST_IDLE))
        err_q <= 1'b0;
    end
  end

  load_align u_load_align (
    .word   (load_buf),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  assign instc_o     = instc_i;
  assign reg_waddr_o = reg_waddr_i;
  assign mem_rena_o  = mem_rena_i;
  assign mem_rdata_o = load_data;
  assign reg_wdata_o = ((state == ST_DONE) && !bus_we_o) ? load_data : reg_wdata_i;
  assign reg_wena_o  = reg_wena_i & ~misaligned & ~arst &
                       ~((state == ST_DONE) & err_q);
  assign mem_wena_o  = mem_wena_i & ~misaligned & ~arst;

endmodule
